bcd_field_editor: RTL and testbench

Parametrised successor to the clock/calendar edit block. It holds NUM_FIELDS two-digit BCD fields, mirrors the live time/date bus while idle, and edits a shadow copy using up/down/left/right/enter/return pulses. Per-field min/max wrap limits are parameters, and the block generates the digit blink mask and blink phase itself. It sits between the debounced-button block and the 7-segment display mux, and drives a one-cycle load strobe into the timekeeping counters.

---
 rtl/bcd_edit_pkg.sv | 48 ++++
 rtl/bcd_field_editor_if.sv | 35 +++
 rtl/blink_gen.sv | 38 +++
 rtl/bcd_field_editor.sv | 212 +++++++++++++++++++++
 tb/tb_bcd_field_editor.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_edit_pkg.sv
// Shared state encoding and wrap-around BCD arithmetic for the two-digit field editor.
package bcd_edit_pkg;

    localparam int FIELD_W = 8;

    typedef enum logic [1:0] {
        DISPLAY = 2'd0,
        EDIT    = 2'd1,
        COMMIT  = 2'd2
    } edit_state_e;

    // Both nibbles are decimal digits and the value lies inside [min_v, max_v].
    function automatic logic bcd_in_range(input logic [FIELD_W-1:0] value,
                                          input logic [FIELD_W-1:0] min_v,
                                          input logic [FIELD_W-1:0] max_v);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9) &&
               (value >= min_v) && (value <= max_v);
    endfunction

    function automatic logic [FIELD_W-1:0] bcd_inc_wrap(input logic [FIELD_W-1:0] value,
                                                        input logic [FIELD_W-1:0] min_v,
                                                        input logic [FIELD_W-1:0] max_v);
        logic [FIELD_W-1:0] result;
        if (!bcd_in_range(value, min_v, max_v) || (value == max_v)) begin
            result = min_v;
        end else if (value[3:0] == 4'd9) begin
            result = {value[7:4] + 4'd1, 4'd0};
        end else begin
            result = {value[7:4], value[3:0] + 4'd1};
        end
        return result;
    endfunction

    function automatic logic [FIELD_W-1:0] bcd_dec_wrap(input logic [FIELD_W-1:0] value,
                                                        input logic [FIELD_W-1:0] min_v,
                                                        input logic [FIELD_W-1:0] max_v);
        logic [FIELD_W-1:0] result;
        if (!bcd_in_range(value, min_v, max_v) || (value == min_v)) begin
            result = max_v;
        end else if (value[3:0] == 4'd0) begin
            result = {value[7:4] - 4'd1, 4'd9};
        end else begin
            result = {value[7:4], value[3:0] - 4'd1};
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_field_editor_if.sv
// Button/bus bundle between the debouncer, the field editor and the display/timekeeping side.
interface bcd_field_editor_if #(
    parameter int NUM_FIELDS = 6
);
    localparam int SEL_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;

    logic [NUM_FIELDS*8-1:0] live_bcd_in;
    logic                    up_btn;
    logic                    down_btn;
    logic                    left_btn;
    logic                    right_btn;
    logic                    enter_btn;
    logic                    return_btn;
    logic [NUM_FIELDS*8-1:0] bcd_out;
    logic                    load_valid;
    logic [NUM_FIELDS*8-1:0] load_bcd;
    logic                    editing;
    logic [SEL_W-1:0]        sel_field;
    logic [NUM_FIELDS*2-1:0] blink_mask;
    logic                    blink_phase;
    logic                    edit_timeout;

    modport master (
        output live_bcd_in, up_btn, down_btn, left_btn, right_btn, enter_btn, return_btn,
        input  bcd_out, load_valid, load_bcd, editing, sel_field, blink_mask, blink_phase,
               edit_timeout
    );

    modport slave (
        input  live_bcd_in, up_btn, down_btn, left_btn, right_btn, enter_btn, return_btn,
        output bcd_out, load_valid, load_bcd, editing, sel_field, blink_mask, blink_phase,
               edit_timeout
    );

endinterface

// File: rtl/blink_gen.sv
// Blink phase generator: phase toggles every BLINK_DIV enabled cycles; restart forces a fresh lit half.
module blink_gen #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic restart,
    output logic phase
);
    localparam int CNT_W = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic [CNT_W-1:0] count_r;
    logic             phase_r;

    // Half-period counter and phase flop; restart has priority over the idle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
            phase_r <= 1'b0;
        end else if (restart) begin
            count_r <= {CNT_W{1'b0}};
            phase_r <= 1'b1;
        end else if (!enable) begin
            count_r <= {CNT_W{1'b0}};
            phase_r <= 1'b0;
        end else if (count_r == CNT_LAST) begin
            count_r <= {CNT_W{1'b0}};
            phase_r <= ~phase_r;
        end else begin
            count_r <= count_r + CNT_W'(1);
        end
    end

    assign phase = phase_r;

endmodule

// File: rtl/bcd_field_editor.sv
// Two-digit BCD field editor: mirrors the live bus, edits a shadow copy and commits it on enter.
// Define EDIT_TIMEOUT_EN to abort an idle edit after TIMEOUT_CYCLES.
module bcd_field_editor
    import bcd_edit_pkg::*;
#(
    parameter int NUM_FIELDS = 6,
    parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MAX = {8'h99, 8'h12, 8'h31, 8'h23, 8'h59, 8'h59},
    parameter logic [NUM_FIELDS*FIELD_W-1:0] FIELD_MIN = {8'h00, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00},
    parameter int BLINK_DIV      = 25_000_000,
    parameter int TIMEOUT_CYCLES = 500_000_000
) (
    input logic               clk,
    input logic               rst_n,
    bcd_field_editor_if.slave bus
);
    localparam int BUS_W = NUM_FIELDS * FIELD_W;
    localparam int SEL_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_FIELDS - 1);

    edit_state_e             state_r;
    edit_state_e             state_next;
    logic [BUS_W-1:0]        shadow_r;
    logic [BUS_W-1:0]        shadow_next;
    logic [SEL_W-1:0]        sel_r;
    logic [SEL_W-1:0]        sel_next;
    logic [BUS_W-1:0]        bcd_out_r;
    logic [BUS_W-1:0]        load_bcd_r;
    logic                    load_valid_r;
    logic                    editing_r;
    logic [NUM_FIELDS*2-1:0] mask_r;
    logic [FIELD_W-1:0]      cur_field_s;
    logic [FIELD_W-1:0]      cur_min_s;
    logic [FIELD_W-1:0]      cur_max_s;
    logic                    restart_s;
    logic                    blink_en_s;
    logic                    blink_phase_s;

    function automatic logic [FIELD_W-1:0] get_field(input logic [BUS_W-1:0] vec,
                                                     input logic [SEL_W-1:0] idx);
        logic [FIELD_W-1:0] result;
        result = {FIELD_W{1'b0}};
        for (int i = 0; i < NUM_FIELDS; i++) begin
            result = (idx == SEL_W'(i)) ? vec[(NUM_FIELDS-i)*FIELD_W-1 -: FIELD_W] : result;
        end
        return result;
    endfunction

    function automatic logic [BUS_W-1:0] put_field(input logic [BUS_W-1:0] vec,
                                                   input logic [SEL_W-1:0] idx,
                                                   input logic [FIELD_W-1:0] value);
        logic [BUS_W-1:0] result;
        result = vec;
        for (int i = 0; i < NUM_FIELDS; i++) begin
            result[(NUM_FIELDS-i)*FIELD_W-1 -: FIELD_W] =
                (idx == SEL_W'(i)) ? value : vec[(NUM_FIELDS-i)*FIELD_W-1 -: FIELD_W];
        end
        return result;
    endfunction

    // Both digits of the selected field blink; bit order follows the bus (field 0 in the MSBs).
    function automatic logic [NUM_FIELDS*2-1:0] sel_mask(input logic [SEL_W-1:0] idx);
        logic [NUM_FIELDS*2-1:0] result;
        result = {(NUM_FIELDS*2){1'b0}};
        for (int i = 0; i < NUM_FIELDS; i++) begin
            result[(NUM_FIELDS-i)*2-1 -: 2] = (idx == SEL_W'(i)) ? 2'b11 : 2'b00;
        end
        return result;
    endfunction

`ifdef EDIT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_r;
    logic            edit_timeout_r;
    logic            timeout_fire_s;
    logic            any_btn_s;

    assign any_btn_s = bus.up_btn | bus.down_btn | bus.left_btn | bus.right_btn |
                       bus.enter_btn | bus.return_btn;
`endif

    // Value under edit and its wrap limits.
    always_comb begin
        cur_field_s = get_field(shadow_r, sel_r);
        cur_min_s   = get_field(FIELD_MIN, sel_r);
        cur_max_s   = get_field(FIELD_MAX, sel_r);
    end

    // Next-state, shadow and selection logic; one action per cycle in fixed priority order.
    always_comb begin
        state_next  = state_r;
        shadow_next = shadow_r;
        sel_next    = sel_r;
        restart_s   = 1'b0;
`ifdef EDIT_TIMEOUT_EN
        timeout_fire_s = 1'b0;
`endif
        case (state_r)
            DISPLAY: begin
                if (bus.enter_btn) begin
                    state_next  = EDIT;
                    shadow_next = bus.live_bcd_in;
                    sel_next    = {SEL_W{1'b0}};
                    restart_s   = 1'b1;
                end else begin
                    state_next = DISPLAY;
                end
            end
            EDIT: begin
                if (bus.return_btn) begin
                    state_next = DISPLAY;
                end else if (bus.enter_btn) begin
                    state_next = COMMIT;
                end else if (bus.up_btn) begin
                    shadow_next = put_field(shadow_r, sel_r,
                                            bcd_inc_wrap(cur_field_s, cur_min_s, cur_max_s));
                    restart_s   = 1'b1;
                end else if (bus.down_btn) begin
                    shadow_next = put_field(shadow_r, sel_r,
                                            bcd_dec_wrap(cur_field_s, cur_min_s, cur_max_s));
                    restart_s   = 1'b1;
                end else if (bus.left_btn) begin
                    sel_next  = (sel_r == {SEL_W{1'b0}}) ? SEL_LAST : sel_r - SEL_W'(1);
                    restart_s = 1'b1;
                end else if (bus.right_btn) begin
                    sel_next  = (sel_r == SEL_LAST) ? {SEL_W{1'b0}} : sel_r + SEL_W'(1);
                    restart_s = 1'b1;
                end else begin
`ifdef EDIT_TIMEOUT_EN
                    if (to_cnt_r == TO_LAST) begin
                        state_next     = DISPLAY;
                        timeout_fire_s = 1'b1;
                    end else begin
                        state_next = EDIT;
                    end
`else
                    state_next = EDIT;
`endif
                end
            end
            COMMIT: begin
                state_next = DISPLAY;
            end
            default: begin
                state_next = DISPLAY;
            end
        endcase
    end

    assign blink_en_s = (state_next == EDIT);

    // Control state, shadow copy and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= DISPLAY;
            shadow_r     <= {BUS_W{1'b0}};
            sel_r        <= {SEL_W{1'b0}};
            bcd_out_r    <= {BUS_W{1'b0}};
            load_bcd_r   <= {BUS_W{1'b0}};
            load_valid_r <= 1'b0;
            editing_r    <= 1'b0;
            mask_r       <= {(NUM_FIELDS*2){1'b0}};
        end else begin
            state_r      <= state_next;
            shadow_r     <= shadow_next;
            sel_r        <= sel_next;
            bcd_out_r    <= (state_r == DISPLAY) ? bus.live_bcd_in : shadow_r;
            load_bcd_r   <= (state_next == COMMIT) ? shadow_r : load_bcd_r;
            load_valid_r <= (state_next == COMMIT);
            editing_r    <= (state_next == EDIT);
            mask_r       <= (state_next == EDIT) ? sel_mask(sel_next) : {(NUM_FIELDS*2){1'b0}};
        end
    end

`ifdef EDIT_TIMEOUT_EN
    // Idle counter: runs only while staying in EDIT with no button, cleared by any press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_r       <= {TO_W{1'b0}};
            edit_timeout_r <= 1'b0;
        end else begin
            to_cnt_r       <= ((state_r == EDIT) && (state_next == EDIT) && !any_btn_s) ?
                              to_cnt_r + TO_W'(1) : {TO_W{1'b0}};
            edit_timeout_r <= timeout_fire_s;
        end
    end

    assign bus.edit_timeout = edit_timeout_r;
`else
    assign bus.edit_timeout = 1'b0;
`endif

    blink_gen #(
        .BLINK_DIV (BLINK_DIV)
    ) u_blink_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (blink_en_s),
        .restart (restart_s),
        .phase   (blink_phase_s)
    );

    assign bus.bcd_out     = bcd_out_r;
    assign bus.load_valid  = load_valid_r;
    assign bus.load_bcd    = load_bcd_r;
    assign bus.editing     = editing_r;
    assign bus.sel_field   = sel_r;
    assign bus.blink_mask  = mask_r;
    assign bus.blink_phase = blink_phase_s;

endmodule

// File: tb/tb_bcd_field_editor.sv
// Randomized bench for bcd_field_editor against a decimal-arithmetic reference model.
module tb_bcd_field_editor;
    localparam int NF = 6;
    localparam int W  = NF * 8;
    localparam int BD = 4;
    localparam int TO = 20;

    localparam logic [5:0] B_RET   = 6'b100000;
    localparam logic [5:0] B_ENTER = 6'b010000;
    localparam logic [5:0] B_UP    = 6'b001000;
    localparam logic [5:0] B_DOWN  = 6'b000100;
    localparam logic [5:0] B_LEFT  = 6'b000010;
    localparam logic [5:0] B_RIGHT = 6'b000001;

    localparam int MS_DISP   = 0;
    localparam int MS_EDIT   = 1;
    localparam int MS_COMMIT = 2;

    int MAX_DEC [NF] = '{99, 12, 31, 23, 59, 59};
    int MIN_DEC [NF] = '{0, 1, 1, 0, 0, 0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [W-1:0] live_v = '0;
    int n_vec = 0;
    int n_err = 0;

    logic [7:0]    m_shadow [NF];
    int            m_state, m_sel, m_since, m_idle;
    logic [W-1:0]  e_bcd_out, e_load_bcd;
    logic          e_load_valid, e_timeout;
    logic [2*NF-1:0] e_mask;

    bcd_field_editor_if #(.NUM_FIELDS(NF)) bus ();

    bcd_field_editor #(
        .NUM_FIELDS     (NF),
        .BLINK_DIV      (BD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit fld_ok(input logic [7:0] b, input int i);
        int hi, lo;
        hi = int'(b[7:4]);
        lo = int'(b[3:0]);
        return (hi <= 9) && (lo <= 9) && (hi * 10 + lo >= MIN_DEC[i]) && (hi * 10 + lo <= MAX_DEC[i]);
    endfunction

    function automatic int dec_of(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    function automatic logic [W-1:0] pack_shadow();
        logic [W-1:0] v;
        for (int i = 0; i < NF; i++) v[(NF-i)*8-1 -: 8] = m_shadow[i];
        return v;
    endfunction

    function automatic logic [W-1:0] rand_live();
        logic [W-1:0] v;
        for (int i = 0; i < NF; i++) begin
            if ($urandom_range(0, 15) == 0) v[(NF-i)*8-1 -: 8] = 8'($urandom_range(0, 255));
            else v[(NF-i)*8-1 -: 8] = to_bcd(int'($urandom_range(MIN_DEC[i], MAX_DEC[i])));
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NF; i++) m_shadow[i] = 8'h00;
        m_state = MS_DISP; m_sel = 0; m_since = 0; m_idle = 0;
        e_bcd_out = '0; e_load_bcd = '0; e_load_valid = 1'b0; e_timeout = 1'b0; e_mask = '0;
    endtask

    // One clock of the specified behaviour, evaluated on the inputs driven for this cycle.
    task automatic model_clock(input logic [5:0] btn, input logic [W-1:0] live);
        int ns;
        bit restart;
        ns = m_state;
        restart = 1'b0;
        e_timeout = 1'b0;
        e_bcd_out = (m_state == MS_DISP) ? live : pack_shadow();
        if (m_state == MS_DISP) begin
            if ((btn & B_ENTER) != 0) begin
                for (int i = 0; i < NF; i++) m_shadow[i] = live[(NF-i)*8-1 -: 8];
                m_sel = 0; ns = MS_EDIT; restart = 1'b1;
            end
        end else if (m_state == MS_EDIT) begin
            restart = (btn != 6'b0);
            if ((btn & B_RET) != 0) ns = MS_DISP;
            else if ((btn & B_ENTER) != 0) ns = MS_COMMIT;
            else if ((btn & B_UP) != 0)
                m_shadow[m_sel] = (!fld_ok(m_shadow[m_sel], m_sel) || dec_of(m_shadow[m_sel]) == MAX_DEC[m_sel]) ?
                                  to_bcd(MIN_DEC[m_sel]) : to_bcd(dec_of(m_shadow[m_sel]) + 1);
            else if ((btn & B_DOWN) != 0)
                m_shadow[m_sel] = (!fld_ok(m_shadow[m_sel], m_sel) || dec_of(m_shadow[m_sel]) == MIN_DEC[m_sel]) ?
                                  to_bcd(MAX_DEC[m_sel]) : to_bcd(dec_of(m_shadow[m_sel]) - 1);
            else if ((btn & B_LEFT) != 0) m_sel = (m_sel + NF - 1) % NF;
            else if ((btn & B_RIGHT) != 0) m_sel = (m_sel + 1) % NF;
`ifdef EDIT_TIMEOUT_EN
            if (btn == 6'b0 && m_idle == TO - 1) begin
                ns = MS_DISP;
                e_timeout = 1'b1;
            end
`endif
        end else begin
            ns = MS_DISP;
        end
        m_idle = (m_state == MS_EDIT && ns == MS_EDIT && btn == 6'b0) ? m_idle + 1 : 0;
        e_load_valid = (ns == MS_COMMIT);
        if (ns == MS_COMMIT) e_load_bcd = pack_shadow();
        m_since = restart ? 0 : ((ns == MS_EDIT) ? m_since + 1 : 0);
        m_state = ns;
        e_mask = (ns == MS_EDIT) ? ({{(2*NF-2){1'b0}}, 2'b11} << (2 * (NF - 1 - m_sel))) : '0;
    endtask

    task automatic compare_all();
        check_eq("bcd_out", bus.bcd_out, e_bcd_out);
        check_eq("load_valid", bus.load_valid, e_load_valid);
        check_eq("load_bcd", bus.load_bcd, e_load_bcd);
        check_eq("editing", bus.editing, (m_state == MS_EDIT));
        check_eq("sel_field", bus.sel_field, 64'(m_sel));
        check_eq("blink_mask", bus.blink_mask, e_mask);
        check_eq("blink_phase", bus.blink_phase, (m_state == MS_EDIT) && ((m_since / BD) % 2 == 0));
        check_eq("edit_timeout", bus.edit_timeout, e_timeout);
    endtask

    task automatic drive(input logic [5:0] btn);
        bus.live_bcd_in = live_v;
        {bus.return_btn, bus.enter_btn, bus.up_btn, bus.down_btn, bus.left_btn, bus.right_btn} = btn;
    endtask

    task automatic clock_and_check(input logic [5:0] btn);
        drive(btn);
        model_clock(btn, live_v);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic step(input logic [5:0] btn);
        @(negedge clk);
        clock_and_check(btn);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(6'b0);
        rst_n = 1'b0;
        #2;
        check_eq("rst_bcd_out", bus.bcd_out, 48'h0);
        check_eq("rst_load_valid", bus.load_valid, 1'b0);
        check_eq("rst_load_bcd", bus.load_bcd, 48'h0);
        check_eq("rst_editing", bus.editing, 1'b0);
        check_eq("rst_sel", bus.sel_field, 3'd0);
        check_eq("rst_mask", bus.blink_mask, 12'h000);
        check_eq("rst_phase", bus.blink_phase, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clock_and_check(6'b0);
    endtask

    initial begin
        drive(6'b0);
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Plan 1: mirror live bus
        live_v = 48'h24_03_15_10_30_00;
        step(6'b0);
        check_eq("t1_mirror", bus.bcd_out, 48'h24_03_15_10_30_00);
        check_eq("t1_editing", bus.editing, 1'b0);

        // Plan 2: enter, up, enter commits 25
        step(B_ENTER);
        step(B_UP);
        step(B_ENTER);
        check_eq("t2_bcd_out", bus.bcd_out, 48'h25_03_15_10_30_00);
        check_eq("t2_load_valid", bus.load_valid, 1'b1);
        check_eq("t2_load_bcd", bus.load_bcd, 48'h25_03_15_10_30_00);
        step(6'b0);
        check_eq("t2_strobe_once", bus.load_valid, 1'b0);
        step(6'b0);
        check_eq("t2_track_live", bus.bcd_out, 48'h24_03_15_10_30_00);

        // Plan 3: seconds wrap and selection wrap
        live_v = 48'h24_03_15_10_30_59;
        step(B_ENTER);
        step(B_LEFT);
        check_eq("t3_sel_left_wrap", bus.sel_field, 3'd5);
        step(B_UP);
        step(6'b0);
        check_eq("t3_sec_up_wrap", bus.bcd_out[7:0], 8'h00);
        step(B_DOWN);
        step(6'b0);
        check_eq("t3_sec_down_wrap", bus.bcd_out[7:0], 8'h59);
        step(B_RIGHT);
        check_eq("t3_sel_right_wrap", bus.sel_field, 3'd0);
        step(B_RET);

        // Plan 4: month down-wrap, invalid day recovery, return beats enter
        live_v = 48'h24_01_3A_10_30_00;
        step(B_ENTER);
        step(B_RIGHT);
        step(B_DOWN);
        step(6'b0);
        check_eq("t4_month_wrap", bus.bcd_out[39:32], 8'h12);
        step(B_RIGHT);
        step(B_UP);
        step(6'b0);
        check_eq("t4_day_invalid", bus.bcd_out[31:24], 8'h01);
        step(B_ENTER | B_RET);
        check_eq("t4_cancel_editing", bus.editing, 1'b0);
        check_eq("t4_cancel_nostrobe", bus.load_valid, 1'b0);
        step(6'b0);
        check_eq("t4_cancel_nostrobe2", bus.load_valid, 1'b0);

        // Plan 5: blink mask and phase
        step(B_ENTER);
        check_eq("t5_mask_sel0", bus.blink_mask, 12'b1100_0000_0000);
        check_eq("t5_phase_enter", bus.blink_phase, 1'b1);
        repeat (4) step(6'b0);
        check_eq("t5_phase_toggle", bus.blink_phase, 1'b0);
        repeat (2) step(6'b0);
        step(B_UP);
        check_eq("t5_phase_restart", bus.blink_phase, 1'b1);
        step(B_RET);

        // Plan 6: idle in EDIT, then a press just before the limit
        step(B_ENTER);
        repeat (TO - 1) step(6'b0);
        check_eq("t6_still_editing", bus.editing, 1'b1);
        step(6'b0);
`ifdef EDIT_TIMEOUT_EN
        check_eq("t6_timeout_pulse", bus.edit_timeout, 1'b1);
        check_eq("t6_timeout_exit", bus.editing, 1'b0);
`else
        check_eq("t6_no_timeout", bus.edit_timeout, 1'b0);
        check_eq("t6_edit_persists", bus.editing, 1'b1);
`endif
        step(B_RET);
        step(B_ENTER);
        repeat (TO - 2) step(6'b0);
        step(B_UP);
        repeat (TO - 1) step(6'b0);
        check_eq("t6_press_keeps_edit", bus.editing, 1'b1);
        step(B_RET);

        // Randomized traffic with occasional resets and long idle stretches
        for (int c = 0; c < 3000; c++) begin
            logic [5:0] b;
            if ($urandom_range(0, 7) == 0) live_v = rand_live();
            if ($urandom_range(0, 99) < 65) b = 6'b0;
            else if ($urandom_range(0, 3) == 0) b = 6'($urandom_range(1, 63));
            else b = 6'b000001 << $urandom_range(0, 5);
            if ($urandom_range(0, 599) == 0) do_reset();
            else step(b);
            if (c % 500 == 250) repeat (TO + 4) step(6'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
